regfile_mp: RTL and testbench

//  Parametrised register file for the pipelined core. It replaces the fixed 2R1W
//  32x32 file. It adds N read ports, optional write-to-read bypass and a per-register

---
 rtl/regfile_mp.sv | 160 ++++++++++++++++
 tb/tb_regfile_mp.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_mp.sv
// -----------------------------------------------------------------------------
// regfile_mp
//   Parametrised multi-read-port register file for the pipelined core.
//   - Register 0 is hardwired to zero: writes and scoreboard sets to it are
//     dropped, and reads of it return 0 with no pending flag.
//   - NREAD combinational read ports, with optional same-cycle write bypass.
//   - Per-register pending scoreboard: set by decode (sb_set), cleared by
//     writeback (we). When both hit one register in the same cycle, the set
//     wins because the newly issued producer supersedes the retiring one.
//   - After reset, a clear sequencer zeroes one register per cycle. The file
//     reports ready once every register has been cleared. Until then, writes
//     and scoreboard sets are ignored and all read outputs are forced to 0.
//
// Ports
//   clk      in   1            rising-edge clock
//   reset    in   1            synchronous, active-high reset
//   we       in   1            write enable
//   wa       in   AW           write address
//   wd       in   WIDTH        write data
//   ra       in   NREAD*AW     read addresses, port i = ra[i*AW +: AW]
//   rd       out  NREAD*WIDTH  read data,      port i = rd[i*WIDTH +: WIDTH]
//   rpend    out  NREAD        register on port i has an outstanding producer
//   sb_set   in   1            mark register sb_addr as pending
//   sb_addr  in   AW           scoreboard set address
//   ready    out  1            clear sequence finished, file usable
// -----------------------------------------------------------------------------
module regfile_mp #(
  parameter  int WIDTH  = 32,
  parameter  int NREGS  = 32,
  parameter  int NREAD  = 2,
  parameter  int BYPASS = 1,
  localparam int AW     = $clog2(NREGS)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   we,
  input  logic [AW-1:0]          wa,
  input  logic [WIDTH-1:0]       wd,
  input  logic [NREAD*AW-1:0]    ra,
  output logic [NREAD*WIDTH-1:0] rd,
  output logic [NREAD-1:0]       rpend,
  input  logic                   sb_set,
  input  logic [AW-1:0]          sb_addr,
  output logic                   ready
);

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_READY = 1'b1
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [AW-1:0]    r_idx;
  logic [AW-1:0]    w_idx_nxt;

  logic [WIDTH-1:0] r_rf [NREGS];
  logic [NREGS-1:0] r_pend;

  logic             w_ready;
  logic             w_wr_en;
  logic             w_sb_en;

  assign w_ready = (r_state == ST_READY);
  assign w_wr_en = w_ready && we     && (wa      != '0);
  assign w_sb_en = w_ready && sb_set && (sb_addr != '0);
  assign ready   = w_ready;

  // ---------------------------------------------------------------------------
  // Clear sequencer: state register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking (<=) so every flop samples the
  // pre-edge values, independent of the order the always blocks execute in.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_CLEAR;
      r_idx   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // Clear sequencer: next state
  // ---------------------------------------------------------------------------
  // NOTE: defaults first, so no path through the case leaves an output
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    unique case (r_state)
      ST_CLEAR: begin
        w_idx_nxt = r_idx + AW'(1);
        if (r_idx == AW'(NREGS - 1)) begin
          w_state_nxt = ST_READY;
        end
      end
      ST_READY: begin
        w_state_nxt = ST_READY;
      end
      default: begin
        w_state_nxt = ST_CLEAR;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Storage array
  // ---------------------------------------------------------------------------
  // NOTE: the array has no reset branch. Zeroing happens through the clear
  // sequencer, one entry per cycle, so the storage can map onto plain RAM
  // or flops without a wide reset fan-out.
  always_ff @(posedge clk) begin
    if (!w_ready) begin
      r_rf[r_idx] <= '0;
    end else if (w_wr_en) begin
      r_rf[wa] <= wd;
    end
  end

  // ---------------------------------------------------------------------------
  // Pending scoreboard
  // ---------------------------------------------------------------------------
  // The set is written after the clear, so when both target the same
  // register, the last assignment (the set) is the one that takes effect.
  // Bit 0 is never set because w_sb_en excludes address 0.
  always_ff @(posedge clk) begin
    if (reset || !w_ready) begin
      r_pend <= '0;
    end else begin
      if (w_wr_en) begin
        r_pend[wa] <= 1'b0;
      end
      if (w_sb_en) begin
        r_pend[sb_addr] <= 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Read ports
  // ---------------------------------------------------------------------------
  for (genvar g = 0; g < NREAD; g++) begin : g_rd
    logic [AW-1:0] w_addr;
    logic          w_live;
    logic          w_hit;

    assign w_addr = ra[g*AW +: AW];
    // Address 0 and the CLEAR phase both force the port to zero and not pending.
    assign w_live = w_ready && (w_addr != '0);
    // w_wr_en already excludes wa == 0, so a hit implies a non-zero address.
    assign w_hit  = (BYPASS != 0) && w_wr_en && (wa == w_addr);

    assign rd[g*WIDTH +: WIDTH] = !w_live ? '0 :
                                  w_hit   ? wd : r_rf[w_addr];
    assign rpend[g]             = w_live && r_pend[w_addr] && !w_hit;
  end

endmodule

// File: tb/tb_regfile_mp.sv
// -----------------------------------------------------------------------------
// tb_regfile_mp
//   Two instances share one set of stimulus:
//     u_dut_a : NREAD=4, BYPASS=1
//     u_dut_b : NREAD=2, BYPASS=0 (its read addresses are ports 0..1 of u_dut_a)
//   The reference model tracks cycles since reset, register contents and
//   pending flags directly. All outputs of both instances are compared against
//   it on every falling edge, and the directed steps add spot checks.
// -----------------------------------------------------------------------------
module tb_regfile_mp;

  localparam int WIDTH = 32;
  localparam int NREGS = 32;
  localparam int AW    = 5;
  localparam int NRA   = 4;
  localparam int NRB   = 2;

  logic                 clk;
  logic                 reset;
  logic                 we;
  logic [AW-1:0]        wa;
  logic [WIDTH-1:0]     wd;
  logic [NRA*AW-1:0]    ra;
  logic                 sb_set;
  logic [AW-1:0]        sb_addr;

  logic [NRA*WIDTH-1:0] rd_a;
  logic [NRA-1:0]       rpend_a;
  logic                 ready_a;
  logic [NRB*WIDTH-1:0] rd_b;
  logic [NRB-1:0]       rpend_b;
  logic                 ready_b;

  int checks   = 0;
  int failures = 0;

  // Reference model state
  logic [WIDTH-1:0] m_rf   [NREGS];
  bit               m_pend [NREGS];
  int               m_cnt;      // clean cycles since reset was released
  bit               m_known = 1'b0;

  regfile_mp #(.WIDTH(WIDTH), .NREGS(NREGS), .NREAD(NRA), .BYPASS(1)) u_dut_a (
    .clk     (clk),
    .reset   (reset),
    .we      (we),
    .wa      (wa),
    .wd      (wd),
    .ra      (ra),
    .rd      (rd_a),
    .rpend   (rpend_a),
    .sb_set  (sb_set),
    .sb_addr (sb_addr),
    .ready   (ready_a)
  );

  regfile_mp #(.WIDTH(WIDTH), .NREGS(NREGS), .NREAD(NRB), .BYPASS(0)) u_dut_b (
    .clk     (clk),
    .reset   (reset),
    .we      (we),
    .wa      (wa),
    .wd      (wd),
    .ra      (ra[NRB*AW-1:0]),
    .rd      (rd_b),
    .rpend   (rpend_b),
    .sb_set  (sb_set),
    .sb_addr (sb_addr),
    .ready   (ready_b)
  );

  // Clock starts high, so the first event is a falling edge and the first
  // rising edge is the one the model sees with reset asserted.
  initial begin
    clk = 1'b1;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [WIDTH-1:0] obs,
                       input logic [WIDTH-1:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic bit m_ready();
    return m_known && (m_cnt >= NREGS);
  endfunction

  function automatic bit m_bypass_hit(input logic [AW-1:0] a, input bit byp);
    return byp && we && (wa == a) && (a != '0);
  endfunction

  function automatic logic [WIDTH-1:0] exp_rd(input logic [AW-1:0] a, input bit byp);
    if (!m_ready() || a == '0) return '0;
    if (m_bypass_hit(a, byp))  return wd;
    return m_rf[a];
  endfunction

  function automatic logic exp_pend(input logic [AW-1:0] a, input bit byp);
    if (!m_ready() || a == '0) return 1'b0;
    return m_pend[a] && !m_bypass_hit(a, byp);
  endfunction

  // Falling edge: compare every output of both instances with the model.
  task automatic sample();
    logic [AW-1:0] a;
    @(negedge clk);
    if (m_known) begin
      check("ready_a", {31'd0, ready_a}, {31'd0, m_ready()});
      check("ready_b", {31'd0, ready_b}, {31'd0, m_ready()});
      for (int p = 0; p < NRA; p++) begin
        a = ra[p*AW +: AW];
        check($sformatf("rd_a%0d@r%0d", p, a), rd_a[p*WIDTH +: WIDTH], exp_rd(a, 1'b1));
        check($sformatf("rpend_a%0d@r%0d", p, a), {31'd0, rpend_a[p]},
              {31'd0, exp_pend(a, 1'b1)});
      end
      for (int p = 0; p < NRB; p++) begin
        a = ra[p*AW +: AW];
        check($sformatf("rd_b%0d@r%0d", p, a), rd_b[p*WIDTH +: WIDTH], exp_rd(a, 1'b0));
        check($sformatf("rpend_b%0d@r%0d", p, a), {31'd0, rpend_b[p]},
              {31'd0, exp_pend(a, 1'b0)});
      end
    end
  endtask

  // Rising edge: advance the model with the inputs that were applied.
  task automatic edge_update();
    @(posedge clk);
    if (reset) begin
      m_known = 1'b1;
      m_cnt   = 0;
      for (int r = 0; r < NREGS; r++) begin
        m_rf[r]   = '0;
        m_pend[r] = 1'b0;
      end
    end else if (m_known && m_cnt < NREGS) begin
      m_cnt++;
    end else if (m_known) begin
      if (we && wa != '0) begin
        m_rf[wa]   = wd;
        m_pend[wa] = 1'b0;
      end
      if (sb_set && sb_addr != '0) m_pend[sb_addr] = 1'b1;
    end
    #1;
  endtask

  task automatic cycle();
    sample();
    edge_update();
  endtask

  task automatic idle();
    reset  = 1'b0;
    we     = 1'b0;
    sb_set = 1'b0;
  endtask

  task automatic set_ra(input int p, input int a);
    ra[p*AW +: AW] = AW'(a);
  endtask

  // Runs cycles until ready_a rises, bounded, and checks the count.
  task automatic wait_ready(input string tag);
    int k;
    k = 0;
    while (ready_a !== 1'b1 && k < 40) begin
      cycle();
      idle();
      k++;
    end
    check(tag, k, NREGS);
  endtask

  initial begin
    reset = 1'b1; we = 1'b0; wa = '0; wd = '0; ra = '0; sb_set = 1'b0; sb_addr = '0;

    // 1. One reset cycle, then exactly NREGS clear cycles with all outputs zero.
    cycle();
    idle();
    for (int p = 0; p < NRA; p++) set_ra(p, p * 7 + 1);
    wait_ready("t1_ready_latency");
    for (int r = 0; r < NREGS; r += 4) begin
      for (int p = 0; p < NRA; p++) set_ra(p, r + p);
      cycle();
    end

    // 2. Write r5 while reading it: bypass shows new data now, no-bypass next.
    we = 1'b1; wa = 5'd5; wd = 32'hDEADBEEF; set_ra(0, 5);
    sample();
    check("t2_bypass_same", rd_a[31:0], 32'hDEADBEEF);
    check("t2_nobypass_same", rd_b[31:0], 32'h0);
    edge_update();
    idle();
    sample();
    check("t2_bypass_next", rd_a[31:0], 32'hDEADBEEF);
    check("t2_nobypass_next", rd_b[31:0], 32'hDEADBEEF);
    edge_update();

    // 3. Write plus scoreboard set aimed at r0 are both discarded.
    we = 1'b1; wa = 5'd0; wd = 32'hFFFF_FFFF; sb_set = 1'b1; sb_addr = 5'd0; set_ra(0, 0);
    sample();
    check("t3_r0_bypass", rd_a[31:0], 32'h0);
    edge_update();
    idle();
    sample();
    check("t3_r0_read", rd_a[31:0], 32'h0);
    check("t3_r0_pend", {31'd0, rpend_a[0]}, 32'h0);
    edge_update();

    // 4. Scoreboard set, resolve by write, then set and write together.
    sb_set = 1'b1; sb_addr = 5'd7; set_ra(1, 7);
    cycle();
    idle();
    sample();
    check("t4_pend_set", {31'd0, rpend_a[1]}, 32'h1);
    edge_update();
    we = 1'b1; wa = 5'd7; wd = 32'h0000_0777;
    sample();
    check("t4_pend_bypass", {31'd0, rpend_a[1]}, 32'h0);
    check("t4_pend_nobypass", {31'd0, rpend_b[1]}, 32'h1);
    edge_update();
    idle();
    sample();
    check("t4_pend_after", {31'd0, rpend_a[1]}, 32'h0);
    edge_update();
    we = 1'b1; wa = 5'd7; wd = 32'h0000_0888; sb_set = 1'b1; sb_addr = 5'd7;
    cycle();
    idle();
    sample();
    check("t4_set_wins", {31'd0, rpend_a[1]}, 32'h1);
    check("t4_set_wins_data", rd_a[63:32], 32'h0000_0888);
    edge_update();

    // 5. Reset mid-clear restarts the sequence; a write during CLEAR is ignored.
    we = 1'b1; wa = 5'd3; wd = 32'h0000_1234;
    cycle();
    idle();
    reset = 1'b1;
    cycle();
    idle();
    for (int c = 0; c < 10; c++) cycle();
    reset = 1'b1;
    cycle();
    idle();
    we = 1'b1; wa = 5'd3; wd = 32'hBAD0_BAD0; sb_set = 1'b1; sb_addr = 5'd3;
    wait_ready("t5_ready_latency");
    set_ra(0, 3); set_ra(1, 3);
    sample();
    check("t5_r3_cleared", rd_a[31:0], 32'h0);
    check("t5_r3_not_pend", {31'd0, rpend_a[0]}, 32'h0);
    edge_update();

    // 6. Three ports read r9 while one reads r0.
    we = 1'b1; wa = 5'd9; wd = 32'hA5A5A5A5;
    cycle();
    idle();
    set_ra(0, 9); set_ra(1, 9); set_ra(2, 0); set_ra(3, 9);
    sample();
    check("t6_port0", rd_a[0*WIDTH +: WIDTH], 32'hA5A5A5A5);
    check("t6_port1", rd_a[1*WIDTH +: WIDTH], 32'hA5A5A5A5);
    check("t6_port2_r0", rd_a[2*WIDTH +: WIDTH], 32'h0);
    check("t6_port3", rd_a[3*WIDTH +: WIDTH], 32'hA5A5A5A5);
    edge_update();

    // 7. Random traffic on a narrow address range so hazards and bypasses collide.
    for (int c = 0; c < 500; c++) begin
      reset   = ($urandom_range(0, 249) == 0);
      we      = $urandom_range(0, 1) == 1;
      wa      = AW'($urandom_range(0, 7));
      wd      = $urandom;
      sb_set  = $urandom_range(0, 2) == 0;
      sb_addr = AW'($urandom_range(0, 7));
      for (int p = 0; p < NRA; p++) set_ra(p, $urandom_range(0, 7));
      cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
